// File: rtl/div_unit_if.sv
// Pipeline-to-divider handshake and operand/result bundle.
// The pipeline drives the master side and the divider drives the slave side.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             abandon;
    logic             signdiv;
    logic [WIDTH-1:0] opr1;
    logic [WIDTH-1:0] opr2;
    logic             busy;
    logic             ready;
    logic             dbz;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;

    modport master (
        output start, abandon, signdiv, opr1, opr2,
        input  busy, ready, dbz, quot, rem
    );

    modport slave (
        input  start, abandon, signdiv, opr1, opr2,
        output busy, ready, dbz, quot, rem
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider with signed/unsigned operands,
// optional leading-zero early-out and an explicit divide-by-zero flag.
module div_unit #(
    parameter int WIDTH     = 32,
    parameter int EARLY_OUT = 1
) (
    input  logic      clk,
    input  logic      rst,
    div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    function automatic logic [CW-1:0] lzc(input logic [WIDTH-1:0] v);
        logic [CW-1:0] n;
        logic          found;
        n     = {CW{1'b0}};
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found && !v[i]) begin
                n = n + CW'(1);
            end else begin
                found = 1'b1;
            end
        end
        return n;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + ONE_W) : v;
    endfunction

    state_e           state_q;
    logic             neg1_q, neg2_q, zdiv_q;
    logic [WIDTH-1:0] opr1_q, a_q, b_q, rp_q, dv_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, ready_q, dbz_q;
    logic [WIDTH-1:0] quot_q, rem_q;

    logic [WIDTH:0]   shl_s;
    logic             ge_s;
    logic [WIDTH-1:0] rp_d, dv_d;
    logic [CW-1:0]    lz_s, n_s;
    logic [WIDTH-1:0] quot_d, rem_d;

    // One restoring step: shift in the next dividend bit and trial-subtract the divisor.
    always_comb begin
        shl_s = {rp_q, dv_q[WIDTH-1]};
        ge_s  = (shl_s >= {1'b0, b_q});
        if (ge_s) begin
            rp_d = WIDTH'(shl_s - {1'b0, b_q});
            dv_d = {dv_q[WIDTH-2:0], 1'b1};
        end else begin
            rp_d = shl_s[WIDTH-1:0];
            dv_d = {dv_q[WIDTH-2:0], 1'b0};
        end
    end

    // Iteration count: zero-magnitude dividends skip straight to the sign fix-up.
    always_comb begin
        if (EARLY_OUT != 0) begin
            lz_s = lzc(a_q);
        end else begin
            lz_s = {CW{1'b0}};
        end
        n_s = CW'(WIDTH) - lz_s;
    end

    // Final result; MIN/-1 needs no special case since negating MIN yields MIN.
    always_comb begin
        if (zdiv_q) begin
            quot_d = ONES_W;
            rem_d  = opr1_q;
        end else begin
            quot_d = cond_neg(dv_q, neg1_q ^ neg2_q);
            rem_d  = cond_neg(rp_q, neg1_q);
        end
    end

    // Control FSM, operand capture, iteration datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            neg1_q  <= 1'b0;
            neg2_q  <= 1'b0;
            zdiv_q  <= 1'b0;
            opr1_q  <= ZERO_W;
            a_q     <= ZERO_W;
            b_q     <= ZERO_W;
            rp_q    <= ZERO_W;
            dv_q    <= ZERO_W;
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            dbz_q   <= 1'b0;
            quot_q  <= ZERO_W;
            rem_q   <= ZERO_W;
        end else if (bus.abandon) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            dbz_q   <= 1'b0;
            quot_q  <= ZERO_W;
            rem_q   <= ZERO_W;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        neg1_q <= bus.signdiv & bus.opr1[WIDTH-1];
                        neg2_q <= bus.signdiv & bus.opr2[WIDTH-1];
                        opr1_q <= bus.opr1;
                        a_q    <= cond_neg(bus.opr1, bus.signdiv & bus.opr1[WIDTH-1]);
                        b_q    <= cond_neg(bus.opr2, bus.signdiv & bus.opr2[WIDTH-1]);
                        zdiv_q <= (bus.opr2 == ZERO_W);
                        busy_q <= 1'b1;
                        if (bus.opr2 == ZERO_W) begin
                            state_q <= S_FIX;
                        end else begin
                            state_q <= S_PREP;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_PREP: begin
                    dv_q  <= a_q << lz_s;
                    rp_q  <= ZERO_W;
                    cnt_q <= n_s;
                    if (n_s == {CW{1'b0}}) begin
                        state_q <= S_FIX;
                    end else begin
                        state_q <= S_DIV;
                    end
                end
                S_DIV: begin
                    rp_q  <= rp_d;
                    dv_q  <= dv_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_FIX;
                    end else begin
                        state_q <= S_DIV;
                    end
                end
                S_FIX: begin
                    quot_q  <= quot_d;
                    rem_q   <= rem_d;
                    dbz_q   <= zdiv_q;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    if (!bus.start) begin
                        ready_q <= 1'b0;
                        dbz_q   <= 1'b0;
                        quot_q  <= ZERO_W;
                        rem_q   <= ZERO_W;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                    dbz_q   <= 1'b0;
                    quot_q  <= ZERO_W;
                    rem_q   <= ZERO_W;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.ready = ready_q;
    assign bus.dbz   = dbz_q;
    assign bus.quot  = quot_q;
    assign bus.rem   = rem_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: three instances (32-bit full latency,
// 32-bit early-out, 8-bit early-out) checked against an arithmetic model.
module tb_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    div_unit_if #(.WIDTH(32)) if0 ();
    div_unit_if #(.WIDTH(32)) if1 ();
    div_unit_if #(.WIDTH(8))  if2 ();

    div_unit #(.WIDTH(32), .EARLY_OUT(0)) u_div0 (.clk(clk), .rst(rst), .bus(if0));
    div_unit #(.WIDTH(32), .EARLY_OUT(1)) u_div1 (.clk(clk), .rst(rst), .bus(if1));
    div_unit #(.WIDTH(8),  .EARLY_OUT(1)) u_div2 (.clk(clk), .rst(rst), .bus(if2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int wid(input int u);
        return (u == 2) ? 8 : 32;
    endfunction

    function automatic bit eo(input int u);
        return (u != 0);
    endfunction

    function automatic logic [63:0] wmask(input int w);
        logic [63:0] one;
        one = 64'd1;
        return (one << w) - 64'd1;
    endfunction

    function automatic longint sx(input logic [63:0] v, input int w);
        return $signed(v << (64 - w)) >>> (64 - w);
    endfunction

    // Reference: plain integer division, truncating toward zero.
    task automatic model(input int w, input bit sd, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] q, output logic [63:0] r, output bit z);
        longint sa, sb;
        z = (b == 64'd0);
        if (z) begin
            q = wmask(w);
            r = a;
        end else if (sd) begin
            sa = sx(a, w);
            sb = sx(b, w);
            q  = 64'(sa / sb) & wmask(w);
            r  = 64'(sa % sb) & wmask(w);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    function automatic int exp_lat(input int w, input bit e, input bit sd, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] m;
        int n;
        if (b == 64'd0) return 1;
        if (!e) return w + 2;
        m = (sd && sx(a, w) < 0) ? 64'(-sx(a, w)) : a;
        n = 0;
        while (m != 64'd0) begin
            n++;
            m = m >> 1;
        end
        return n + 2;
    endfunction

    task automatic drive(input int u, input bit st, input bit ab, input bit sd,
                         input logic [63:0] a, input logic [63:0] b);
        case (u)
            0: begin if0.start = st; if0.abandon = ab; if0.signdiv = sd; if0.opr1 = a[31:0]; if0.opr2 = b[31:0]; end
            1: begin if1.start = st; if1.abandon = ab; if1.signdiv = sd; if1.opr1 = a[31:0]; if1.opr2 = b[31:0]; end
            default: begin if2.start = st; if2.abandon = ab; if2.signdiv = sd; if2.opr1 = a[7:0]; if2.opr2 = b[7:0]; end
        endcase
    endtask

    task automatic sample(input int u, output logic bz, output logic rd, output logic dz,
                          output logic [63:0] q, output logic [63:0] r);
        case (u)
            0: begin bz = if0.busy; rd = if0.ready; dz = if0.dbz; q = 64'(if0.quot); r = 64'(if0.rem); end
            1: begin bz = if1.busy; rd = if1.ready; dz = if1.dbz; q = 64'(if1.quot); r = 64'(if1.rem); end
            default: begin bz = if2.busy; rd = if2.ready; dz = if2.dbz; q = 64'(if2.quot); r = 64'(if2.rem); end
        endcase
    endtask

    // One full transaction; operands are scrambled right after capture.
    task automatic run_op(input int u, input bit sd, input logic [63:0] a_in, input logic [63:0] b_in, input int hold);
        logic [63:0] a, b, eq, er, qo, ro;
        bit   ez;
        logic bz, rd, dz;
        int   w, elat, lat, bcnt;
        w = wid(u);
        a = a_in & wmask(w);
        b = b_in & wmask(w);
        model(w, sd, a, b, eq, er, ez);
        elat = exp_lat(w, eo(u), sd, a, b);
        drive(u, 1'b1, 1'b0, sd, a, b);
        @(posedge clk); #1;
        drive(u, 1'b1, 1'b0, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
        sample(u, bz, rd, dz, qo, ro);
        bcnt = bz ? 1 : 0;
        lat  = 0;
        for (int k = 1; k <= 80 && lat == 0; k++) begin
            @(posedge clk); #1;
            sample(u, bz, rd, dz, qo, ro);
            if (rd) lat = k;
            else if (bz) bcnt++;
        end
        chk("latency", 64'(lat), 64'(elat));
        chk("busy_cycles", 64'(bcnt), 64'(elat));
        chk("busy_at_ready", 64'(bz), 64'd0);
        chk("quot", qo, eq);
        chk("rem", ro, er);
        chk("dbz", 64'(dz), 64'(ez));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            sample(u, bz, rd, dz, qo, ro);
            chk("hold_ready", 64'(rd), 64'd1);
            chk("hold_quot", qo, eq);
            chk("hold_rem", ro, er);
        end
        drive(u, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        @(posedge clk); #1;
        sample(u, bz, rd, dz, qo, ro);
        chk("drop_ready", 64'(rd), 64'd0);
        chk("drop_dbz", 64'(dz), 64'd0);
        chk("drop_result", qo | ro, 64'd0);
    endtask

    initial begin
        logic bz, rd, dz;
        logic [63:0] qo, ro;
        bit seen;
        for (int u = 0; u < 3; u++) drive(u, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            sample(u, bz, rd, dz, qo, ro);
            chk("reset_flags", {61'd0, bz, rd, dz}, 64'd0);
            chk("reset_result", qo | ro, 64'd0);
        end
        rst = 1'b1;
        @(posedge clk); #1;

        run_op(0, 1'b0, 64'd100, 64'd7, 5);
        run_op(0, 1'b1, 64'hFFFF_FFF9, 64'd2, 0);
        run_op(0, 1'b1, 64'd7, 64'hFFFF_FFFE, 0);
        run_op(0, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 0);
        run_op(0, 1'b0, 64'hFFFF_FFF9, 64'd2, 0);
        run_op(0, 1'b0, 64'h1234, 64'd0, 0);
        run_op(1, 1'b0, 64'd5, 64'd3, 0);
        run_op(1, 1'b0, 64'd0, 64'd9, 0);
        run_op(1, 1'b0, 64'hFFFF_FFFF, 64'd1, 0);
        run_op(1, 1'b1, 64'h1234, 64'd0, 0);
        run_op(2, 1'b0, 64'd200, 64'd13, 0);
        run_op(2, 1'b1, 64'h80, 64'hFF, 0);

        for (int i = 0; i < 10; i++) begin
            for (int u = 0; u < 3; u++) begin
                run_op(u, 1'($urandom_range(0, 1)),
                       {$urandom, $urandom} >> $urandom_range(0, 63),
                       {$urandom, $urandom} >> $urandom_range(0, 63), 0);
            end
        end

        // Abandon in the 10th DIV cycle, then ready must never rise.
        drive(0, 1'b1, 1'b0, 1'b0, 64'hDEAD_BEEF, 64'h1234);
        @(posedge clk); #1;
        repeat (10) begin @(posedge clk); #1; end
        sample(0, bz, rd, dz, qo, ro);
        chk("abandon_pre_busy", 64'(bz), 64'd1);
        drive(0, 1'b0, 1'b1, 1'b0, 64'd0, 64'd0);
        @(posedge clk); #1;
        sample(0, bz, rd, dz, qo, ro);
        chk("abandon_busy", 64'(bz), 64'd0);
        chk("abandon_ready", 64'(rd), 64'd0);
        drive(0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            sample(0, bz, rd, dz, qo, ro);
            if (rd || bz) seen = 1'b1;
        end
        chk("abandon_quiet", 64'(seen), 64'd0);

        // Reset in the middle of DIV.
        drive(0, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF, 64'd3);
        @(posedge clk); #1;
        repeat (6) begin @(posedge clk); #1; end
        sample(0, bz, rd, dz, qo, ro);
        chk("rst_pre_busy", 64'(bz), 64'd1);
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        @(posedge clk); #1;
        sample(0, bz, rd, dz, qo, ro);
        chk("rst_mid_flags", {61'd0, bz, rd, dz}, 64'd0);
        chk("rst_mid_result", qo | ro, 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        run_op(0, 1'b0, 64'd100, 64'd7, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
